// File: rtl/mem_responder.sv
// Bus responder for the multicycle core: word RAM, CLINT MMIO (msip/mtimecmp/mtime) and fault decode.
// Optional fault logging (badaddr at +0xC000, fault_valid at +0xC004) is built when MEM_RESP_FAULT_LOG_EN is defined.
module mem_responder #(
   parameter int unsigned RAM_WORDS = 4096,
   parameter logic [31:0] MMIO_BASE = 32'h0200_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_re,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wd,
   input  logic [1:0]  mem_rd_unit,
   input  logic [1:0]  mem_wd_unit,
   output logic [31:0] mem_rd,
   input  logic [63:0] mtime,
   input  logic [63:0] mtimecmp,
   output logic [63:0] mtime_next,
   output logic [63:0] mtimecmp_next,
   output logic        mtime_we,
   output logic        msip,
   output logic        access_fault,
   output logic        addr_misaligned
);

   localparam int unsigned AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) * 33'd4;

   logic [1:0]  unit;
   logic [29:0] word_addr;
   logic        active, misaligned, reserved, unmapped, legal, wr_ok, rd_ok;
   logic        in_ram, hit_msip, hit_cmp_lo, hit_cmp_hi, hit_time_lo, hit_time_hi, log_hit;
   logic [3:0]  byte_en;
   logic [31:0] bit_mask, wd_lanes, rd_word, rd_shift, rd_mask, ram_rdata;
   logic [AW-1:0] ram_idx;
   logic        msip_reg;

   assign active    = mem_re | mem_we;
   assign unit      = mem_we ? mem_wd_unit : mem_rd_unit;
   assign word_addr = mem_addr[31:2];
   assign ram_idx   = mem_addr[AW+1:2];

   assign in_ram      = {1'b0, mem_addr} < RAM_BYTES;
   assign hit_msip    = word_addr == 30'((MMIO_BASE + 32'h0000_0000) >> 2);
   assign hit_cmp_lo  = word_addr == 30'((MMIO_BASE + 32'h0000_4000) >> 2);
   assign hit_cmp_hi  = word_addr == 30'((MMIO_BASE + 32'h0000_4004) >> 2);
   assign hit_time_lo = word_addr == 30'((MMIO_BASE + 32'h0000_BFF8) >> 2);
   assign hit_time_hi = word_addr == 30'((MMIO_BASE + 32'h0000_BFFC) >> 2);

`ifdef MEM_RESP_FAULT_LOG_EN
   logic [31:0] badaddr_reg;
   logic        fault_valid_reg;
   logic        hit_badaddr, hit_fvalid;
   assign hit_badaddr = word_addr == 30'((MMIO_BASE + 32'h0000_C000) >> 2);
   assign hit_fvalid  = word_addr == 30'((MMIO_BASE + 32'h0000_C004) >> 2);
   assign log_hit     = hit_badaddr | hit_fvalid;
`else
   assign log_hit     = 1'b0;
`endif

   assign misaligned = ((unit == 2'b01) && mem_addr[0]) || ((unit == 2'b10) && (mem_addr[1:0] != 2'b00));
   assign reserved   = unit == 2'b11;
   assign unmapped   = !(in_ram | hit_msip | hit_cmp_lo | hit_cmp_hi | hit_time_lo | hit_time_hi | log_hit);

   assign addr_misaligned = active & misaligned;
   assign access_fault    = active & !misaligned & (unmapped | reserved);
   assign legal           = active & !misaligned & !unmapped & !reserved;
   // Reset blocks every state-changing effect, including the core-held timer updates.
   assign wr_ok           = legal & mem_we & reset;
   assign rd_ok           = legal & mem_re & !mem_we;

   always_comb begin
      byte_en = 4'b0000;
      case (unit)
         2'b00:   byte_en = 4'b0001 << mem_addr[1:0];
         2'b01:   byte_en = 4'b0011 << mem_addr[1:0];
         2'b10:   byte_en = 4'b1111;
         default: byte_en = 4'b0000;
      endcase
   end

   assign wd_lanes = mem_wd << {mem_addr[1:0], 3'b000};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [RAM_WORDS];
         assign bit_mask[8*gi +: 8] = {8{byte_en[gi]}};
         always_ff @(posedge clk) begin
            if (wr_ok && in_ram && byte_en[gi])
               lane_mem[ram_idx] <= wd_lanes[8*gi +: 8];
         end
         assign ram_rdata[8*gi +: 8] = lane_mem[ram_idx];
      end
   endgenerate

   function automatic logic [31:0] merge_lanes(input logic [31:0] old, input logic [31:0] data,
                                               input logic [31:0] mask);
      return (old & ~mask) | (data & mask);
   endfunction

   always_comb begin
      mtimecmp_next = mtimecmp;
      mtime_next    = mtime;
      mtime_we      = 1'b0;
      if (wr_ok && hit_cmp_lo) mtimecmp_next[31:0]  = merge_lanes(mtimecmp[31:0], wd_lanes, bit_mask);
      if (wr_ok && hit_cmp_hi) mtimecmp_next[63:32] = merge_lanes(mtimecmp[63:32], wd_lanes, bit_mask);
      if (wr_ok && hit_time_lo) begin
         mtime_next[31:0] = merge_lanes(mtime[31:0], wd_lanes, bit_mask);
         mtime_we         = 1'b1;
      end
      if (wr_ok && hit_time_hi) begin
         mtime_next[63:32] = merge_lanes(mtime[63:32], wd_lanes, bit_mask);
         mtime_we          = 1'b1;
      end
   end

   always_comb begin
      rd_word = ram_rdata;
      if (hit_msip)         rd_word = {31'b0, msip_reg};
      else if (hit_cmp_lo)  rd_word = mtimecmp[31:0];
      else if (hit_cmp_hi)  rd_word = mtimecmp[63:32];
      else if (hit_time_lo) rd_word = mtime[31:0];
      else if (hit_time_hi) rd_word = mtime[63:32];
`ifdef MEM_RESP_FAULT_LOG_EN
      else if (hit_badaddr) rd_word = badaddr_reg;
      else if (hit_fvalid)  rd_word = {31'b0, fault_valid_reg};
`endif
   end

   assign rd_shift = rd_word >> {mem_addr[1:0], 3'b000};
   assign rd_mask  = (unit == 2'b00) ? 32'h0000_00FF : (unit == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
   assign mem_rd   = rd_ok ? (rd_shift & rd_mask) : 32'h0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         msip_reg        <= 1'b0;
`ifdef MEM_RESP_FAULT_LOG_EN
         badaddr_reg     <= 32'h0;
         fault_valid_reg <= 1'b0;
`endif
      end else begin
         if (wr_ok && hit_msip) msip_reg <= mem_wd[0];
`ifdef MEM_RESP_FAULT_LOG_EN
         // Only the first fault after a clear is kept; later faults leave badaddr alone.
         if ((access_fault || addr_misaligned) && !fault_valid_reg) begin
            badaddr_reg     <= mem_addr;
            fault_valid_reg <= 1'b1;
         end else if (wr_ok && hit_fvalid) begin
            fault_valid_reg <= 1'b0;
         end
`endif
      end
   end

   assign msip = msip_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: byte-array RAM model and 64-bit byte-level timer model.
module tb_mem_responder;

   localparam logic [31:0] MMIO = 32'h0200_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        mem_re = 1'b0, mem_we = 1'b0;
   logic [31:0] mem_addr = 32'h0, mem_wd = 32'h0;
   logic [1:0]  mem_rd_unit = 2'b10, mem_wd_unit = 2'b10;
   logic [31:0] mem_rd;
   logic [63:0] mtime = 64'h0, mtimecmp = 64'h0;
   logic [63:0] mtime_next, mtimecmp_next;
   logic        mtime_we, msip, access_fault, addr_misaligned;

   int tests_run = 0;
   int tests_failed = 0;
   logic [7:0] ram_m [0:255];

   mem_responder dut (
      .clk(clk), .reset(reset), .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wd(mem_wd), .mem_rd_unit(mem_rd_unit), .mem_wd_unit(mem_wd_unit), .mem_rd(mem_rd),
      .mtime(mtime), .mtimecmp(mtimecmp), .mtime_next(mtime_next), .mtimecmp_next(mtimecmp_next),
      .mtime_we(mtime_we), .msip(msip), .access_fault(access_fault), .addr_misaligned(addr_misaligned)
   );

   always #5 clk = ~clk;

   // Drive one request mid-cycle and let the combinational outputs settle.
   task automatic apply(input logic re, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] u);
      mem_re = re; mem_we = we; mem_addr = a; mem_wd = wd; mem_rd_unit = u; mem_wd_unit = u;
      #3;
      $display("[TB] txn re=%0b we=%0b addr=%h wd=%h unit=%0d rd=%h af=%0b ma=%0b",
               re, we, a, wd, u, mem_rd, access_fault, addr_misaligned);
   endtask

   task automatic tick();
      @(posedge clk); #1;
      mem_re = 1'b0; mem_we = 1'b0;
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] u);
      logic [31:0] v = 32'h0;
      for (int k = 0; k < (1 << u); k++) v[8*k +: 8] = ram_m[a[7:0] + 8'(k)];
      return v;
   endfunction

   task automatic model_store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] u);
      for (int k = 0; k < (1 << u); k++) ram_m[a[7:0] + 8'(k)] = wd[8*k +: 8];
   endtask

   function automatic logic [63:0] merge64(input logic [63:0] old, input int idx,
                                           input logic [31:0] wd, input logic [1:0] u);
      logic [63:0] v = old;
      for (int k = 0; k < (1 << u); k++) v[8*(idx+k) +: 8] = wd[8*k +: 8];
      return v;
   endfunction

   task automatic test_reset();
      #2;
      tests_run++;
      if (msip !== 1'b0) begin tests_failed++; $display("FAIL reset_msip got=%b want=0", msip); end
      tests_run++;
      if ({mem_rd, access_fault, addr_misaligned, mtime_we} !== 35'h0) begin
         tests_failed++;
         $display("FAIL reset_idle got rd=%h af=%b ma=%b mwe=%b want all 0", mem_rd, access_fault, addr_misaligned, mtime_we);
      end
      @(posedge clk); #2; reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_ram_directed();
      apply(0, 1, 32'h10, 32'hDEADBEEF, 2'b10); tick(); model_store(32'h10, 32'hDEADBEEF, 2'b10);
      apply(1, 0, 32'h11, 32'h0, 2'b00);
      tests_run++;
      if (mem_rd !== 32'h0000_00BE) begin tests_failed++; $display("FAIL ld_byte_11 got=%h want=000000be", mem_rd); end
      tick();
      apply(1, 0, 32'h12, 32'h0, 2'b01);
      tests_run++;
      if (mem_rd !== 32'h0000_DEAD) begin tests_failed++; $display("FAIL ld_half_12 got=%h want=0000dead", mem_rd); end
      tick();
      apply(0, 1, 32'h13, 32'h0000_0055, 2'b00); tick(); model_store(32'h13, 32'h55, 2'b00);
      apply(1, 0, 32'h10, 32'h0, 2'b10);
      tests_run++;
      if ({mem_rd, access_fault, addr_misaligned} !== {32'h55ADBEEF, 2'b00}) begin
         tests_failed++;
         $display("FAIL ld_word_merged got=%h af=%b ma=%b want=55adbeef 0 0", mem_rd, access_fault, addr_misaligned);
      end
      tick();
   endtask

   task automatic test_ram_random();
      logic [31:0] a, wd, exp;
      logic [1:0]  u;
      for (int i = 0; i < 64; i++) begin
         wd = $urandom;
         apply(0, 1, 32'(i * 4), wd, 2'b10); tick(); model_store(32'(i * 4), wd, 2'b10);
      end
      for (int i = 0; i < 80; i++) begin
         u  = 2'($urandom_range(0, 2));
         a  = 32'($urandom_range(0, 252)) & ~((32'd1 << u) - 32'd1);
         wd = $urandom;
         if ($urandom_range(0, 1) == 1) begin
            apply(0, 1, a, wd, u);
            tests_run++;
            if ({mem_rd, access_fault, addr_misaligned} !== 34'h0) begin
               tests_failed++;
               $display("FAIL rand_store_%0d got rd=%h af=%b ma=%b want 0", i, mem_rd, access_fault, addr_misaligned);
            end
            tick(); model_store(a, wd, u);
         end else begin
            exp = model_load(a, u);
            apply(1, 0, a, 32'h0, u);
            tests_run++;
            if ({mem_rd, access_fault, addr_misaligned} !== {exp, 2'b00}) begin
               tests_failed++;
               $display("FAIL rand_load_%0d addr=%h got=%h want=%h", i, a, mem_rd, exp);
            end
            tick();
         end
      end
   endtask

   task automatic test_timers();
      logic [63:0] exp;
      logic [31:0] wd, a;
      logic [1:0]  u;
      int idx;
      mtime = 64'h1_0000_0005; mtimecmp = 64'h0123_4567_89AB_CDEF;
      apply(0, 1, MMIO + 32'hBFF8, 32'h20, 2'b10);
      tests_run++;
      if ({mtime_we, mtime_next, mtimecmp_next} !== {1'b1, 64'h1_0000_0020, mtimecmp}) begin
         tests_failed++;
         $display("FAIL mtime_store got we=%b next=%h cmp=%h want 1 100000020", mtime_we, mtime_next, mtimecmp_next);
      end
      tick(); #3;
      tests_run++;
      if ({mtime_we, mtime_next} !== {1'b0, mtime}) begin
         tests_failed++;
         $display("FAIL mtime_idle got we=%b next=%h want 0 %h", mtime_we, mtime_next, mtime);
      end
      mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF;
      apply(0, 1, MMIO + 32'h4004, 32'h3, 2'b10);
      tests_run++;
      if ({mtimecmp_next, mtime_we} !== {64'h0000_0003_FFFF_FFFF, 1'b0}) begin
         tests_failed++;
         $display("FAIL mtimecmp_store got=%h we=%b want 00000003ffffffff 0", mtimecmp_next, mtime_we);
      end
      tick(); #3;
      tests_run++;
      if (mtimecmp_next !== mtimecmp) begin
         tests_failed++; $display("FAIL mtimecmp_idle got=%h want=%h", mtimecmp_next, mtimecmp);
      end
      for (int i = 0; i < 24; i++) begin
         mtime = {$urandom, $urandom}; mtimecmp = {$urandom, $urandom};
         u   = 2'($urandom_range(0, 2));
         idx = int'($urandom_range(0, 7)) & ~((1 << u) - 1);
         wd  = $urandom;
         if (i % 3 == 0) begin
            a = MMIO + 32'h4000 + 32'(idx);
            apply(0, 1, a, wd, u);
            exp = merge64(mtimecmp, idx, wd, u);
            tests_run++;
            if ({mtimecmp_next, mtime_we} !== {exp, 1'b0}) begin
               tests_failed++; $display("FAIL rand_cmp_%0d got=%h want=%h", i, mtimecmp_next, exp);
            end
         end else if (i % 3 == 1) begin
            a = MMIO + 32'hBFF8 + 32'(idx);
            apply(0, 1, a, wd, u);
            exp = merge64(mtime, idx, wd, u);
            tests_run++;
            if ({mtime_next, mtime_we, mtimecmp_next} !== {exp, 1'b1, mtimecmp}) begin
               tests_failed++; $display("FAIL rand_time_%0d got=%h we=%b want=%h", i, mtime_next, mtime_we, exp);
            end
         end else begin
            a = MMIO + 32'hBFF8 + 32'(idx);
            apply(1, 0, a, 32'h0, u);
            exp = (mtime >> (8 * idx)) & ((64'd1 << (8 << u)) - 64'd1);
            tests_run++;
            if ({mem_rd, mtime_we} !== {exp[31:0], 1'b0}) begin
               tests_failed++; $display("FAIL rand_time_load_%0d got=%h want=%h", i, mem_rd, exp[31:0]);
            end
         end
         tick();
      end
   endtask

   task automatic test_errors();
      logic [31:0] exp;
      apply(0, 1, MMIO, 32'h1, 2'b00); tick();
      apply(0, 1, 32'h3FFC, 32'hCAFE_F00D, 2'b10); tick();
      mtime = 64'h55;
      apply(1, 0, 32'h6, 32'h0, 2'b10);
      tests_run++;
      if ({addr_misaligned, access_fault, mem_rd} !== {2'b10, 32'h0}) begin
         tests_failed++; $display("FAIL mis_ld_word got ma=%b af=%b rd=%h want 1 0 0", addr_misaligned, access_fault, mem_rd);
      end
      tick();
      apply(0, 1, 32'h1, 32'hFFFF, 2'b01);
      tests_run++;
      if ({addr_misaligned, access_fault} !== 2'b10) begin
         tests_failed++; $display("FAIL mis_st_half got ma=%b af=%b want 1 0", addr_misaligned, access_fault);
      end
      tick();
      apply(0, 1, MMIO + 32'hBFFA, 32'h0, 2'b10);
      tests_run++;
      if ({addr_misaligned, mtime_we, mtime_next} !== {2'b10, mtime}) begin
         tests_failed++; $display("FAIL mis_mtime got ma=%b we=%b next=%h want 1 0 %h", addr_misaligned, mtime_we, mtime_next, mtime);
      end
      tick();
      apply(0, 1, MMIO + 32'h2, 32'h0, 2'b10); tick();
      apply(1, 0, 32'h3000_0000, 32'h0, 2'b10);
      tests_run++;
      if ({addr_misaligned, access_fault, mem_rd} !== {2'b01, 32'h0}) begin
         tests_failed++; $display("FAIL unmapped_ld got ma=%b af=%b rd=%h want 0 1 0", addr_misaligned, access_fault, mem_rd);
      end
      tick();
      apply(1, 0, 32'h10, 32'h0, 2'b11);
      tests_run++;
      if ({addr_misaligned, access_fault, mem_rd} !== {2'b01, 32'h0}) begin
         tests_failed++; $display("FAIL reserved_unit got ma=%b af=%b rd=%h want 0 1 0", addr_misaligned, access_fault, mem_rd);
      end
      tick();
      apply(0, 1, 32'h4000, 32'h0, 2'b10);
      tests_run++;
      if (access_fault !== 1'b1) begin tests_failed++; $display("FAIL ram_end+1 af got=%b want=1", access_fault); end
      tick();
      apply(0, 1, MMIO + 32'h8, 32'h0, 2'b10);
      tests_run++;
      if (access_fault !== 1'b1) begin tests_failed++; $display("FAIL mmio_hole af got=%b want=1", access_fault); end
      tick();
      apply(1, 0, 32'h3FFC, 32'h0, 2'b10);
      tests_run++;
      if ({mem_rd, access_fault} !== {32'hCAFE_F00D, 1'b0}) begin
         tests_failed++; $display("FAIL ram_last_word got=%h af=%b want=cafef00d 0", mem_rd, access_fault);
      end
      tick();
      exp = model_load(32'h0, 2'b10);
      apply(1, 0, 32'h0, 32'h0, 2'b10);
      tests_run++;
      if ({mem_rd, msip} !== {exp, 1'b1}) begin
         tests_failed++; $display("FAIL after_errors got rd=%h msip=%b want=%h 1", mem_rd, msip, exp);
      end
      tick();
   endtask

   task automatic test_msip_reset();
      logic [31:0] exp;
      apply(0, 1, MMIO, 32'h0, 2'b00); tick();
      tests_run++;
      if (msip !== 1'b0) begin tests_failed++; $display("FAIL msip_byte_clr got=%b want=0", msip); end
      apply(0, 1, MMIO, 32'h1, 2'b01); tick();
      apply(1, 0, MMIO, 32'h0, 2'b10);
      tests_run++;
      if ({msip, mem_rd} !== {1'b1, 32'h1}) begin
         tests_failed++; $display("FAIL msip_half_set got msip=%b rd=%h want 1 1", msip, mem_rd);
      end
      tick();
      apply(0, 1, MMIO, 32'h1, 2'b10);
      #1 reset = 1'b0; #1;
      tests_run++;
      if (msip !== 1'b0) begin tests_failed++; $display("FAIL msip_async_reset got=%b want=0", msip); end
      @(posedge clk); #1;
      tests_run++;
      if (msip !== 1'b0) begin tests_failed++; $display("FAIL msip_held_in_reset got=%b want=0", msip); end
      exp = model_load(32'h40, 2'b10);
      mem_addr = 32'h40; mem_wd = ~exp;
      @(posedge clk); #1;
      mem_addr = MMIO; mem_wd = 32'h1;
      #2 reset = 1'b1;
      tick();
      tests_run++;
      if (msip !== 1'b1) begin tests_failed++; $display("FAIL msip_after_release got=%b want=1", msip); end
      apply(1, 0, 32'h40, 32'h0, 2'b10);
      tests_run++;
      if (mem_rd !== exp) begin tests_failed++; $display("FAIL ram_write_in_reset got=%h want=%h", mem_rd, exp); end
      tick();
   endtask

   task automatic test_fault_log();
`ifdef MEM_RESP_FAULT_LOG_EN
      apply(1, 0, MMIO + 32'hC004, 32'h0, 2'b10);
      tests_run++;
      if (mem_rd !== 32'h0) begin tests_failed++; $display("FAIL fv_initial got=%h want=0", mem_rd); end
      tick();
      apply(1, 0, 32'h3000_0000, 32'h0, 2'b10); tick();
      apply(1, 0, 32'h3000_0004, 32'h0, 2'b10); tick();
      apply(1, 0, MMIO + 32'hC000, 32'h0, 2'b10);
      tests_run++;
      if (mem_rd !== 32'h3000_0000) begin tests_failed++; $display("FAIL badaddr got=%h want=30000000", mem_rd); end
      tick();
      apply(1, 0, MMIO + 32'hC004, 32'h0, 2'b10);
      tests_run++;
      if (mem_rd !== 32'h1) begin tests_failed++; $display("FAIL fv_set got=%h want=1", mem_rd); end
      tick();
      apply(0, 1, MMIO + 32'hC004, 32'h0, 2'b10); tick();
      apply(1, 0, MMIO + 32'hC004, 32'h0, 2'b10);
      tests_run++;
      if (mem_rd !== 32'h0) begin tests_failed++; $display("FAIL fv_clear got=%h want=0", mem_rd); end
      tick();
      apply(1, 0, MMIO + 32'hC000, 32'h0, 2'b10);
      tests_run++;
      if (mem_rd !== 32'h3000_0000) begin tests_failed++; $display("FAIL badaddr_kept got=%h want=30000000", mem_rd); end
      tick();
`else
      apply(1, 0, MMIO + 32'hC000, 32'h0, 2'b10);
      tests_run++;
      if ({access_fault, mem_rd} !== {1'b1, 32'h0}) begin
         tests_failed++; $display("FAIL c000_unmapped got af=%b rd=%h want 1 0", access_fault, mem_rd);
      end
      tick();
      apply(0, 1, MMIO + 32'hC004, 32'h0, 2'b10);
      tests_run++;
      if (access_fault !== 1'b1) begin tests_failed++; $display("FAIL c004_unmapped got af=%b want 1", access_fault); end
      tick();
`endif
   endtask

   initial begin
      test_reset();
      test_ram_directed();
      test_ram_random();
      test_timers();
      test_errors();
      test_msip_reset();
      test_fault_log();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle core's single data/instruction bus.
- Decodes each access into one of three targets:
  - a word-addressed RAM;
  - CLINT-style MMIO registers: msip, mtimecmp, mtime;
  - illegal space, which raises a fault.
- mtime and mtimecmp are held inside the core. This block only computes their next values on stores and returns their values on loads.
- It reports misalignment and access faults in the same cycle as the request.

Parameters:
- RAM_WORDS, 4096, RAM depth in 32-bit words; RAM occupies 0x0000_0000 .. RAM_WORDS*4-1.
- MMIO_BASE, 32'h0200_0000, base of CLINT window.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- mem_re  in  1  read request.
- mem_we  in  1  write request.
- mem_addr  in  32  byte address.
- mem_wd  in  32  write data, right-aligned.
- mem_rd_unit  in  2  read size: 00 byte, 01 half, 10 word, 11 reserved.
- mem_wd_unit  in  2  write size, same encoding.
- mem_rd  out  32  read data, right-aligned, upper bits zero.
- mtime  in  64  current mtime from core.
- mtimecmp  in  64  current mtimecmp from core.
- mtime_next  out  64  value the core loads when mtime_we=1.
- mtimecmp_next  out  64  next mtimecmp; the core loads it every cycle.
- mtime_we  out  1  store to mtime this cycle.
- msip  out  1  software interrupt pending, bit 0 of the msip register.
- access_fault  out  1  unmapped address or reserved unit.
- addr_misaligned  out  1  misaligned access.

Behaviour:
- Address map, all offsets from MMIO_BASE:
  - msip at +0x0000;
  - mtimecmp low/high at +0x4000 / +0x4004;
  - mtime low/high at +0xBFF8 / +0xBFFC;
  - everything else outside RAM is unmapped.
- Active unit is mem_wd_unit when mem_we=1, else mem_rd_unit. mem_re and mem_we both high is illegal; mem_we takes precedence.
- Misaligned means: half with addr[0]=1, or word with addr[1:0]!=0.
- Error outputs (all combinational, low when there is no request):
  - addr_misaligned = (mem_re|mem_we) & misaligned.
  - access_fault = (mem_re|mem_we) & !misaligned & (unmapped | unit==11).
  - Misalignment has priority; the two are never both high.
- Any error suppresses all state updates, mtime_we and mtimecmp merges. mem_rd=0 when there is an error or no read.
- Reads are combinational in the same cycle: the selected word is shifted right by 8*addr[1:0] and masked to the unit.
  - RAM uses asynchronous read.
  - msip reads {31'b0, msip}.
  - mtime and mtimecmp halves read from the input ports.
- RAM writes happen at the rising clk edge with byte-lane enables from unit and addr[1:0]. A sub-word write touches only its lanes.
- msip register: written at the clk edge with mem_wd[0]. Byte, half and word writes to +0 all update it.
- mtimecmp_next equals mtimecmp, except during a legal store to a mtimecmp half. Then that 32-bit half is lane-merged with mem_wd and the other half passes through unchanged.
- mtime store:
  - mtime_we=1 combinationally for that cycle;
  - mtime_next = mtime with the addressed half lane-merged;
  - otherwise mtime_next = mtime and mtime_we=0.
- Reset (reset=0, asynchronous):
  - msip=0;
  - RAM contents are not reset;
  - combinational outputs follow the rules above with reset asserted, and all writes are blocked.
- Reset deasserting mid-access: an access only takes effect at the first clk edge with reset=1.

Optional Feature:
- Macro MEM_RESP_FAULT_LOG_EN.
- When defined:
  - badaddr register at +0xC000 and a fault_valid sticky flag are added.
  - On the first clk edge with access_fault or addr_misaligned while fault_valid=0, mem_addr is captured and fault_valid is set.
  - Reading +0xC000 returns badaddr; reading +0xC004 returns {31'b0, fault_valid}.
  - Any legal store to +0xC004 clears fault_valid; badaddr is kept.
  - Both registers are reset to 0.
- When not defined: +0xC000 and +0xC004 are unmapped and raise access_fault.

Test Plan:
- Store word 0xDEADBEEF to 0x10, then load byte at 0x11 -> mem_rd=0x000000BE; load half at 0x12 -> 0x0000DEAD.
- Store byte 0x55 to 0x13 over 0xDEADBEEF, then load word 0x10 -> 0x55ADBEEF; no error flags.
- mtime input 0x1_0000_0005, store word 0x20 to MMIO_BASE+0xBFF8 -> mtime_we=1 that cycle only, mtime_next=0x1_0000_0020.
- mtimecmp input 0xFFFF_FFFF_FFFF_FFFF, store word 0x3 to +0x4004 -> mtimecmp_next=0x0000_0003_FFFF_FFFF; idle cycle -> mtimecmp_next equals input.
- Load word at 0x6, store half at 0x1, load from 0x3000_0000 -> addr_misaligned=1, addr_misaligned=1, access_fault=1 respectively; RAM and msip unchanged, mem_rd=0.
- Store 1 to msip, then assert reset mid-store cycle -> msip=0 immediately; with MEM_RESP_FAULT_LOG_EN, fault at 0x3000_0000 then at 0x3000_0004 -> read +0xC000 = 0x3000_0000.
